// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: DVI 8b/10b video with running disparity, control codes,
// and (with TMDS_HDMI_EN defined) HDMI guard bands and TERC4 data islands.
module tmds_channel_encoder #(
    parameter int unsigned CN = 0
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [7:0] video_data,
    input  logic [1:0] control_data,
    input  logic [3:0] data_island_data,
    output logic [9:0] tmds
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
`ifdef TMDS_HDMI_EN
    localparam logic [2:0] MODE_VGB    = 3'd2;
    localparam logic [2:0] MODE_ISLAND = 3'd3;
    localparam logic [2:0] MODE_IGB    = 3'd4;
    localparam logic [9:0] GB_VIDEO    = (CN == 1) ? 10'b0100110011 : 10'b1011001100;
    localparam logic [9:0] GB_ISLAND   = 10'b0100110011;
`endif

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1_in;
    logic       use_xnor;
    logic [8:0] q_m_d;
    logic [2:0] mode_d;

    always_comb begin
        n1_in = 4'd0;
        for (int i = 0; i < 8; i++) n1_in = n1_in + {3'b000, video_data[i]};
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !video_data[0]);
        q_m_d    = 9'd0;
        q_m_d[0] = video_data[0];
        for (int i = 1; i < 8; i++)
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ video_data[i]) : (q_m_d[i-1] ^ video_data[i]);
        q_m_d[8] = ~use_xnor;
    end

    // Illegal modes, and HDMI modes in a DVI-only build, collapse to control.
    always_comb begin
        mode_d = MODE_CTRL;
        case (mode)
            MODE_VIDEO: mode_d = MODE_VIDEO;
`ifdef TMDS_HDMI_EN
            MODE_VGB, MODE_ISLAND, MODE_IGB: mode_d = mode;
`endif
            default: mode_d = MODE_CTRL;
        endcase
    end

    logic [8:0] s1_q_m;
    logic [2:0] s1_mode;
    logic [1:0] s1_ctrl;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            s1_q_m  <= 9'd0;
            s1_mode <= MODE_CTRL;
            s1_ctrl <= 2'd0;
        end else begin
            s1_q_m  <= q_m_d;
            s1_mode <= mode_d;
            s1_ctrl <= control_data;
        end
    end

`ifdef TMDS_HDMI_EN
    logic [3:0] s1_island;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) s1_island <= 4'd0;
        else        s1_island <= data_island_data;
    end

    function automatic logic [9:0] terc4(input logic [3:0] d);
        case (d)
            4'h0: terc4 = 10'b1010011100;
            4'h1: terc4 = 10'b1001100011;
            4'h2: terc4 = 10'b1011100100;
            4'h3: terc4 = 10'b1011100010;
            4'h4: terc4 = 10'b0101110001;
            4'h5: terc4 = 10'b0100011110;
            4'h6: terc4 = 10'b0110001110;
            4'h7: terc4 = 10'b0100111100;
            4'h8: terc4 = 10'b1011001100;
            4'h9: terc4 = 10'b0100111001;
            4'hA: terc4 = 10'b0110011100;
            4'hB: terc4 = 10'b1011000110;
            4'hC: terc4 = 10'b1010001110;
            4'hD: terc4 = 10'b1001110001;
            4'hE: terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction
`else
    // Island nibble and channel number only select HDMI symbols.
    logic unused_dvi;
    assign unused_dvi = ^{data_island_data, 1'(CN)};
`endif

    // ---------------- stage 2: disparity control and symbol select ----------------
    // cnt is a 5-bit two's-complement value; wrapping arithmetic is exact
    // because the algorithm keeps it within -10..+10.
    logic [4:0] cnt, cnt_d;
    logic [3:0] n1;
    logic [4:0] diff;
    logic [7:0] q;
    logic       q8;
    logic [9:0] tmds_d;

    always_comb begin
        q  = s1_q_m[7:0];
        q8 = s1_q_m[8];
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q[i]};
        diff   = {n1, 1'b0} - 5'd8;
        tmds_d = CTRL_00;
        cnt_d  = 5'd0;
        case (s1_mode)
            MODE_VIDEO: begin
                if ((cnt == 5'd0) || (n1 == 4'd4)) begin
                    tmds_d = {~q8, q8, q8 ? q : ~q};
                    cnt_d  = q8 ? (cnt + diff) : (cnt - diff);
                end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
                    tmds_d = {1'b1, q8, ~q};
                    cnt_d  = cnt - diff + {3'b000, q8, 1'b0};
                end else begin
                    tmds_d = {1'b0, q8, q};
                    cnt_d  = cnt + diff - {3'b000, ~q8, 1'b0};
                end
            end
`ifdef TMDS_HDMI_EN
            MODE_VGB:    tmds_d = GB_VIDEO;
            MODE_ISLAND: tmds_d = terc4(s1_island);
            MODE_IGB:    tmds_d = (CN == 0) ? terc4(s1_island) : GB_ISLAND;
`endif
            default: begin
                case (s1_ctrl)
                    2'b00:   tmds_d = CTRL_00;
                    2'b01:   tmds_d = CTRL_01;
                    2'b10:   tmds_d = CTRL_10;
                    default: tmds_d = CTRL_11;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tmds <= CTRL_00;
            cnt  <= 5'd0;
        end else begin
            tmds <= tmds_d;
            cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: three channels (CN 0..2) share
// stimulus; expected symbols come from a behavioural model of the encoding rules.
module tb_tmds_channel_encoder;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [2:0] mode    = 3'd1;
    logic [7:0] video_data = 8'hFF;
    logic [1:0] control_data = 2'd0;
    logic [3:0] data_island_data = 4'd0;
    logic [9:0] tmds0, tmds1, tmds2;

    tmds_channel_encoder #(.CN(0)) u_cn0 (
        .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .video_data(video_data),
        .control_data(control_data), .data_island_data(data_island_data), .tmds(tmds0));
    tmds_channel_encoder #(.CN(1)) u_cn1 (
        .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .video_data(video_data),
        .control_data(control_data), .data_island_data(data_island_data), .tmds(tmds1));
    tmds_channel_encoder #(.CN(2)) u_cn2 (
        .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .video_data(video_data),
        .control_data(control_data), .data_island_data(data_island_data), .tmds(tmds2));

    // ---------------- clock ----------------
    always #5 clk_pix = ~clk_pix;

    localparam logic [9:0] CTRL_CODES [4] = '{10'b1101010100, 10'b0010101011,
                                              10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC4_TBL [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;

    int checks = 0;
    int errors = 0;
    int model_disp = 0;   // running 1s-0s balance the encoder should be holding
    int obs_bal = 0;      // balance measured on the DUT output
    logic [29:0] exp_q[$];   // {cn2, cn1, cn0}
    logic [8:0]  vid_q[$];   // {is_video, byte}

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int balance(input logic [9:0] s);
        return 2 * $countones(s) - 10;
    endfunction

    function automatic logic [9:0] video_sym(input logic [7:0] d, input int disp);
        int         ones;
        bit         use_xnor, inv, b;
        logic [7:0] q;
        int         n1;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            b    = q[i-1] ^ d[i];
            q[i] = use_xnor ? !b : b;
        end
        n1 = $countones(q);
        if (disp == 0 || n1 == 4)                          inv = use_xnor;
        else if ((disp > 0 && n1 > 4) || (disp < 0 && n1 < 4)) inv = 1'b1;
        else                                               inv = 1'b0;
        return {inv, !use_xnor, inv ? ~q : q};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic model(input logic [2:0] m, input logic [7:0] vd, input logic [1:0] cd,
                         input logic [3:0] id, output logic [29:0] e, output logic [8:0] v);
        int         em;
        logic [9:0] s;
        em = int'(m);
        if (em > 4) em = 0;
`ifndef TMDS_HDMI_EN
        if (em != 1) em = 0;
`endif
        v = 9'd0;
        case (em)
            1: begin
                s = video_sym(vd, model_disp);
                model_disp += balance(s);
                e = {s, s, s};
                v = {1'b1, vd};
            end
            2: e = {GB_A, GB_B, GB_A};
            3: e = {TERC4_TBL[id], TERC4_TBL[id], TERC4_TBL[id]};
            4: e = {GB_B, GB_B, TERC4_TBL[id]};
            default: e = {CTRL_CODES[cd], CTRL_CODES[cd], CTRL_CODES[cd]};
        endcase
        if (em != 1) model_disp = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic pop_and_check();
        logic [29:0] e;
        logic [8:0]  v;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        v = vid_q.pop_front();
        check("tmds_cn0", 32'(tmds0), 32'(e[9:0]));
        check("tmds_cn1", 32'(tmds1), 32'(e[19:10]));
        check("tmds_cn2", 32'(tmds2), 32'(e[29:20]));
        if (v[8]) begin
            check("decode", 32'(decode(tmds0)), 32'(v[7:0]));
            obs_bal += balance(tmds0);
            check("balance_bound", 32'(obs_bal >= -10 && obs_bal <= 10), 32'd1);
        end else begin
            obs_bal = 0;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic [2:0] m, input logic [7:0] vd, input logic [1:0] cd,
                        input logic [3:0] id, input bit kat_en, input logic [29:0] kat);
        logic [29:0] e;
        logic [8:0]  v;
        @(negedge clk_pix);
        pop_and_check();
        mode = m; video_data = vd; control_data = cd; data_island_data = id;
        model(m, vd, cd, id, e, v);
        if (kat_en) e = kat;
        exp_q.push_back(e);
        vid_q.push_back(v);
    endtask

    task automatic do_reset();
        logic [29:0] e;
        logic [8:0]  v;
        @(negedge clk_pix);
        rst_n = 1'b0;
        mode = 3'd1; video_data = 8'hFF; control_data = 2'd0; data_island_data = 4'd0;
        #1;
        check("reset_async", 32'(tmds0), 32'(CTRL_CODES[0]));
        repeat (3) begin
            @(negedge clk_pix);
            check("reset_hold_cn0", 32'(tmds0), 32'(CTRL_CODES[0]));
            check("reset_hold_cn1", 32'(tmds1), 32'(CTRL_CODES[0]));
            check("reset_hold_cn2", 32'(tmds2), 32'(CTRL_CODES[0]));
        end
        rst_n = 1'b1;
        model_disp = 0;
        obs_bal = 0;
        exp_q.delete();
        vid_q.delete();
        exp_q.push_back({3{CTRL_CODES[0]}});
        vid_q.push_back(9'd0);
        model(3'd1, 8'hFF, 2'd0, 4'd0, e, v);
        exp_q.push_back(e);
        vid_q.push_back(v);
    endtask

    // ---------------- sequence ----------------
    initial begin
        do_reset();

        // Disparity walk from cnt = 0 with all-zero pixels.
        step(3'd0, 8'h00, 2'd0, 4'd0, 1'b1, {3{CTRL_CODES[0]}});
        step(3'd1, 8'h00, 2'd0, 4'd0, 1'b1, {3{10'h100}});
        step(3'd1, 8'h00, 2'd0, 4'd0, 1'b1, {3{10'h3FF}});
        step(3'd1, 8'h00, 2'd0, 4'd0, 1'b1, {3{10'h100}});

        for (int c = 0; c < 4; c++)
            step(3'd0, 8'h00, 2'(c), 4'd0, 1'b1, {3{CTRL_CODES[c]}});
        step(3'd1, 8'h00, 2'd0, 4'd0, 1'b1, {3{10'h100}});

`ifdef TMDS_HDMI_EN
        step(3'd2, 8'h00, 2'd0, 4'h0, 1'b1, {GB_A, GB_B, GB_A});
        step(3'd3, 8'h00, 2'd0, 4'h0, 1'b1, {3{10'b1010011100}});
        step(3'd3, 8'h00, 2'd0, 4'h8, 1'b1, {3{10'b1011001100}});
        step(3'd4, 8'h00, 2'd0, 4'hF, 1'b1, {GB_B, GB_B, 10'b1011000011});
`else
        step(3'd3, 8'h00, 2'b01, 4'h0, 1'b1, {3{10'b0010101011}});
        step(3'd2, 8'h00, 2'b10, 4'h5, 1'b1, {3{10'b0101010100}});
        step(3'd4, 8'h00, 2'b11, 4'hF, 1'b1, {3{10'b1010101011}});
`endif
        for (int m = 5; m < 8; m++)
            step(3'(m), 8'hA5, 2'(m - 4), 4'h3, 1'b0, 30'd0);

        // Mode switching every cycle, all fields random.
        for (int i = 0; i < 300; i++)
            step(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0, 30'd0);

        // Long random video run with a reset in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset();
            step(3'd1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'b0, 30'd0);
        end

        repeat (2) step(3'd0, 8'h00, 2'd0, 4'd0, 1'b0, 30'd0);
        @(negedge clk_pix);
        pop_and_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Encodes one TMDS channel, 10 bits per pixel clock, from per-pixel video/control/island data into a symbol for the 10:1 serializer / OBUFDS stage.
- Sits downstream of display_timings and the pixel generator; instantiated three times (CN = 0, 1, 2: blue, green, red).
- Implements DVI 1.0 video encoding with running-disparity tracking, control-period encoding, and HDMI guard-band / TERC4 data-island encoding.

Parameters:
- CN, 0, channel number 0..2; selects guard-band symbols.

Ports:
- clk_pix  input  1  pixel clock; only clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  3  0 control, 1 video, 2 video guard band, 3 data island, 4 island guard band; 5..7 treated as 0.
- video_data  input  8  pixel component, used in mode 1.
- control_data  input  2  {C1,C0}, used in mode 0.
- data_island_data  input  4  TERC4 nibble, used in mode 3; in mode 4 with CN=0 it is encoded as TERC4.
- tmds  output  10  encoded symbol, LSB transmitted first.

Behaviour:
- Reset
  - Asynchronous on rst_n low: all pipeline registers cleared.
  - tmds = 10'b1101010100 (control 00); running disparity cnt = 0.
  - First valid symbol appears 2 cycles after the rst_n deassert edge.
- Latency
  - Fixed 2 clk_pix cycles from inputs to tmds for every mode.
  - Mode, control, and island paths are delayed to match the video path.
- Stage 1 (registered)
  - N1 = popcount(video_data).
  - If N1>4, or N1==4 and video_data[0]==0: XNOR chain, q_m[8]=0; otherwise XOR chain, q_m[8]=1.
  - Register q_m[8:0] together with mode and the side data.
- Stage 2 (registered), video mode
  - n1/n0 = ones/zeros of q_m[7:0].
  - If cnt==0 or n1==n0:
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? n1-n0 : n0-n1.
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - tmds = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + n0 - n1.
  - Else:
    - tmds = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + n1 - n0.
- Disparity counter
  - cnt is 5-bit signed and is bounded to -10..+10 by the algorithm; no saturation logic.
  - Any non-video mode in stage 2 forces cnt to 0.
- Control mode
  - 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- Video guard band
  - CN0/CN2: 1011001100.
  - CN1: 0100110011.
- Data island
  - TERC4 per HDMI 1.4b table (e.g. 0000→1010011100, 1000→1011001100, 1111→1011000011).
- Island guard band
  - CN1/CN2: 0100110011.
  - CN0: TERC4(data_island_data).
- Mode change
  - Takes effect on the symbol exactly 2 cycles later.
  - No bubble; back-to-back mode switches every cycle are legal.
- Reset mid-stream
  - Immediately returns tmds to 1101010100 and cnt to 0.
  - Pipeline contents are discarded.

Optional Feature:
- Macro TMDS_HDMI_EN.
- Defined: modes 2, 3, 4 behave as above.
- Undefined (DVI-only):
  - Modes 2, 3, 4 decode as mode 0 (control, using control_data).
  - TERC4 and guard-band logic are not synthesized.
  - Modes 0 and 1 are unchanged.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mode=1 and video_data=0xFF → tmds=10'b1101010100 throughout; deassert → first video symbol appears 2 cycles later.
- Disparity sequence: mode=1, video_data=0x00 for 3 consecutive cycles starting from cnt=0 → tmds = 0x100, 0x3FF, 0x100; internal cnt = -8, 2, -6.
- Control codes: mode=0, control_data cycling 0,1,2,3 → tmds 1101010100, 0010101011, 0101010100, 1010101011, each at 2-cycle latency. Then mode=1, video_data=0x00 → 0x100, confirming cnt was cleared.
- Guard/island (TMDS_HDMI_EN defined, CN=0):
  - mode=2 → 1011001100.
  - mode=3, nibble 0000 → 1010011100.
  - mode=4, nibble 1111 → 1011000011.
  - Repeat with CN=1: mode=2 and mode=4 → 0100110011.
- DVI build (TMDS_HDMI_EN undefined): mode=3, control_data=2'b01 → 0010101011.
- Random video: 10,000 random bytes in mode=1 → a decoding scoreboard recovers every byte, and the cumulative 1s-0s balance of the output never exceeds ±10 at symbol boundaries. Assert rst_n mid-run → output restarts at 1101010100 with no stale symbols.
